dac_spi_scheduler: RTL

//   Sequences DDS output samples onto the serial DAC link (spi_mosi/spi_sck/spi_cs).

---
 rtl/dac_spi_scheduler.sv | 114 +++++++++++
 1 files changed

// File: rtl/dac_spi_scheduler.sv
// dac_spi_scheduler: frames 12-bit DDS samples as 16-bit SPI mode-0 words with a one-entry pending buffer
//   sysclk       system clock
//   reset        synchronous active-low reset
//   sample_valid one-cycle strobe qualifying sample_data
//   sample_data  unsigned DDS amplitude sample
//   busy         FSM not idle or pending buffer full
//   frame_done   one-cycle pulse in the first cs-high cycle after a completed frame
//   overrun_cnt  saturating count of overwritten pending samples
//   spi_mosi/spi_sck/spi_cs  DAC serial link, cs active low
module dac_spi_scheduler #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W = 12,
  parameter logic [15-DATA_W:0] CTRL_BITS = '0
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       overrun_cnt,
  output logic              spi_mosi,
  output logic              spi_sck,
  output logic              spi_cs
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;
  state_t state;
  logic [CW-1:0] div;
  logic [3:0] bit_idx;
  logic [15:0] shreg;
  logic [DATA_W-1:0] pend;
  logic pend_full;
  logic div_end, consume, direct, start;
  logic [15:0] next_frame;
  assign div_end = div == DIV_LAST;
  // pending sample is taken whenever the FSM is free to start a frame
  assign consume = pend_full && (state == IDLE || (state == GAP && div_end));
  // idle with nothing pending: the strobe bypasses the buffer
  assign direct = state == IDLE && !pend_full && sample_valid;
  assign start = consume || direct;
  assign next_frame = {CTRL_BITS, consume ? pend : sample_data};
  assign busy = state != IDLE || pend_full;
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state <= IDLE;
      div <= '0;
      bit_idx <= '0;
      shreg <= '0;
      pend <= '0;
      pend_full <= 1'b0;
      overrun_cnt <= '0;
      frame_done <= 1'b0;
      spi_mosi <= 1'b0;
      spi_sck <= 1'b0;
      spi_cs <= 1'b1;
    end else begin
      frame_done <= 1'b0;
      if (consume) begin
        pend_full <= sample_valid;
        if (sample_valid) pend <= sample_data;
      end else if (sample_valid && !direct) begin
        pend <= sample_data;
        pend_full <= 1'b1;
        if (pend_full && overrun_cnt != 16'hFFFF) overrun_cnt <= overrun_cnt + 16'd1;
      end
      if (start) begin
        state <= SETUP;
        div <= '0;
        shreg <= next_frame;
        spi_cs <= 1'b0;
        spi_sck <= 1'b0;
        spi_mosi <= next_frame[15];
      end else begin
        case (state)
          SETUP: begin
            div <= div_end ? '0 : div + 1'b1;
            if (div_end) begin
              state <= SHIFT;
              spi_sck <= 1'b1;
              bit_idx <= '0;
            end
          end
          SHIFT: begin
            div <= div_end ? '0 : div + 1'b1;
            if (div_end && spi_sck) begin
              // low half: present the next bit, or 0 once the LSB has been clocked
              spi_sck <= 1'b0;
              shreg <= shreg << 1;
              spi_mosi <= bit_idx != 4'd15 && shreg[14];
            end else if (div_end && bit_idx == 4'd15) begin
              state <= GAP;
              spi_cs <= 1'b1;
              frame_done <= 1'b1;
            end else if (div_end) begin
              bit_idx <= bit_idx + 4'd1;
              spi_sck <= 1'b1;
            end
          end
          GAP: begin
            div <= div_end ? '0 : div + 1'b1;
            if (div_end) state <= IDLE;
          end
          default: begin
            spi_cs <= 1'b1;
            spi_sck <= 1'b0;
            spi_mosi <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule
